sfu_drain: RTL and testbench

- Read-out side of the SFU accumulator bank: once accumulation for a tile finishes, this block walks the 16 per-column psum registers in order.
- Each word is optionally rectified and streamed to the output SRAM writer over a valid/ready handshake with an incrementing address.
- Each entry is cleared after its word is accepted, so the bank starts the next tile at zero.
- Sits between the SFU accumulator bank and the output SRAM port; asserts busy so the controller holds off acc.

---
 rtl/sfu_drain_pkg.sv | 18 +
 rtl/sfu_drain_if.sv | 25 ++
 rtl/sfu_drain.sv | 105 ++++++++++
 tb/tb_sfu_drain.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sfu_drain_pkg.sv
// sfu_pkg: shared SFU constants and drain FSM states.
// Used by sfu_drain and its output interface.
package sfu_pkg;

  localparam int PSUM_BW = 16;
  localparam int NUM_REG = 16;
  localparam int SEL_W   = 4;
  localparam int ADDR_W  = 11;
  localparam int CNT_W   = SEL_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } drain_st_e;

endpackage

// File: rtl/sfu_drain_if.sv
// sfu_drain_if: drained-word stream to the output SRAM writer.
// master = drain block, slave = SRAM writer.
interface sfu_drain_if;
  import sfu_pkg::*;

  logic                      out_valid;
  logic                      out_ready;
  logic signed [PSUM_BW-1:0] out_data;
  logic [ADDR_W-1:0]         out_addr;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    output out_ready
  );

endinterface

// File: rtl/sfu_drain.sv
// sfu_drain: walks the psum bank, streams words to SRAM, clears on accept.
// Optional SFU_DRAIN_RELU_EN rectifies each word at capture.
module sfu_drain
  import sfu_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [4:0]                len,
  input  logic [ADDR_W-1:0]         base_addr,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [SEL_W-1:0]          rd_sel,
  input  logic signed [PSUM_BW-1:0] rd_data,
  output logic                      clr_en,
  output logic [SEL_W-1:0]          clr_sel,
  sfu_drain_if.master               wr
);

  drain_st_e                 state_q;
  drain_st_e                 state_d;
  logic [CNT_W-1:0]          idx_q;
  logic [CNT_W-1:0]          n_q;
  logic [CNT_W-1:0]          n_d;
  logic [ADDR_W-1:0]         addr_q;
  logic signed [PSUM_BW-1:0] data_q;
  logic [ADDR_W-1:0]         oaddr_q;
  logic                      done_q;
  logic                      clr_en_q;
  logic [SEL_W-1:0]          clr_sel_q;
  logic signed [PSUM_BW-1:0] f_data;
  logic                      go;
  logic                      nop;
  logic                      hs;
  logic                      last;

  assign go   = (state_q == IDLE) && start && (len != '0);
  assign nop  = (state_q == IDLE) && start && (len == '0);
  assign hs   = (state_q == SEND) && wr.out_ready;
  assign last = (idx_q == n_q - CNT_W'(1));
  assign n_d  = (len > CNT_W'(NUM_REG)) ? CNT_W'(NUM_REG) : len;

`ifdef SFU_DRAIN_RELU_EN
  assign f_data = rd_data[PSUM_BW-1] ? '0 : rd_data;
`else
  assign f_data = rd_data;
`endif

  // Next-state decode for the drain walk.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go) state_d = READ;
      READ:    state_d = SEND;
      SEND:    if (hs) state_d = last ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, captured word and clear strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      n_q       <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      oaddr_q   <= '0;
      done_q    <= 1'b0;
      clr_en_q  <= 1'b0;
      clr_sel_q <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_d == DONE) || nop;
      clr_en_q <= hs;
      if (go) begin
        n_q    <= n_d;
        addr_q <= base_addr;
        idx_q  <= '0;
      end
      if (state_q == READ) begin
        data_q  <= f_data;
        oaddr_q <= addr_q;
      end
      if (hs) begin
        clr_sel_q <= idx_q[SEL_W-1:0];
        idx_q     <= idx_q + CNT_W'(1);
        addr_q    <= addr_q + ADDR_W'(1);
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign rd_en        = (state_q == READ);
  assign rd_sel       = rd_en ? idx_q[SEL_W-1:0] : '0;
  assign clr_en       = clr_en_q;
  assign clr_sel      = clr_sel_q;
  assign wr.out_valid = (state_q == SEND);
  assign wr.out_data  = data_q;
  assign wr.out_addr  = oaddr_q;

endmodule

// File: tb/tb_sfu_drain.sv
// tb_sfu_drain: random and directed drains against a queue-based model.
// Bank is modelled as an array; expectations come from its snapshot.
module tb_sfu_drain;
  import sfu_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      start = 1'b0;
  logic [4:0]                len = '0;
  logic [ADDR_W-1:0]         base_addr = '0;
  logic                      busy;
  logic                      done;
  logic                      rd_en;
  logic [SEL_W-1:0]          rd_sel;
  logic signed [PSUM_BW-1:0] rd_data;
  logic                      clr_en;
  logic [SEL_W-1:0]          clr_sel;

  sfu_drain_if wr ();

  logic signed [PSUM_BW-1:0] bank [NUM_REG];
  logic signed [PSUM_BW-1:0] snap [NUM_REG];
  logic signed [PSUM_BW-1:0] exp_d [$];
  logic [ADDR_W-1:0]         exp_a [$];
  int                        exp_c [$];
  int n_chk = 0;
  int n_fail = 0;
  int n_done = 0;
  int acc_cnt = 0;
  int rmode = 0;
  int stall = 0;

  always #5 clk = ~clk;

  sfu_drain dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .clr_en    (clr_en),
    .clr_sel   (clr_sel),
    .wr        (wr.master)
  );

  assign rd_data = bank[rd_sel];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [PSUM_BW-1:0] f_ref(
    logic signed [PSUM_BW-1:0] x);
`ifdef SFU_DRAIN_RELU_EN
    return (x < 0) ? '0 : x;
`else
    return x;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset && clr_en) bank[clr_sel] = '0;
  end

  always @(posedge clk) begin
    #1;
    case (rmode)
      1: wr.out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (acc_cnt == 1 && stall < 5) begin
          wr.out_ready = 1'b0;
          if (wr.out_valid) stall++;
        end else begin
          wr.out_ready = 1'b1;
        end
      end
      default: wr.out_ready = 1'b1;
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      if (done) n_done++;
      if (clr_en) begin
        if (exp_c.size() == 0) check("clr_spurious", 32'(clr_sel), 32'hffff);
        else check("clr_sel", 32'(clr_sel), 32'(exp_c.pop_front()));
      end
      if (wr.out_valid) begin
        if (exp_d.size() == 0) begin
          check("valid_spurious", 32'(wr.out_valid), 32'd0);
        end else begin
          check("out_data", 32'(wr.out_data), 32'(exp_d[0]));
          check("out_addr", 32'(wr.out_addr), 32'(exp_a[0]));
          if (wr.out_ready) begin
            void'(exp_d.pop_front());
            void'(exp_a.pop_front());
            exp_c.push_back(acc_cnt);
            acc_cnt++;
          end
        end
      end
    end
  end

  task automatic drain(int ln, int base, int poke);
    int n;
    n = (ln > NUM_REG) ? NUM_REG : ln;
    n_done = 0;
    acc_cnt = 0;
    stall = 0;
    for (int k = 0; k < NUM_REG; k++) snap[k] = bank[k];
    for (int k = 0; k < n; k++) begin
      exp_d.push_back(f_ref(bank[k]));
      exp_a.push_back(ADDR_W'(base + k));
    end
    @(posedge clk); #1;
    start = 1'b1;
    len = 5'(ln);
    base_addr = ADDR_W'(base);
    @(posedge clk); #1;
    start = 1'b0;
    if (n > 0) begin
      check("lat_rd_en", 32'(rd_en), 32'd1);
      check("lat_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("lat_valid", 32'(wr.out_valid), 32'd1);
    end else begin
      check("nop_done", 32'(done), 32'd1);
      check("nop_busy", 32'(busy), 32'd0);
    end
    if (poke > 0) begin
      repeat (poke) @(posedge clk);
      #1;
      start = 1'b1;
      len = 5'd16;
      base_addr = '0;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int c = 0; c < 3000 && n_done == 0; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("done_count", 32'(n_done), 32'd1);
    check("words", 32'(acc_cnt), 32'(n));
    check("left_data", 32'(exp_d.size()), 32'd0);
    check("left_clr", 32'(exp_c.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    for (int k = 0; k < NUM_REG; k++)
      check("bank", 32'(bank[k]), (k < n) ? 32'd0 : 32'(snap[k]));
  endtask

  task automatic rand_bank();
    for (int k = 0; k < NUM_REG; k++) bank[k] = PSUM_BW'($urandom);
  endtask

  initial begin
    wr.out_ready = 1'b1;
    for (int k = 0; k < NUM_REG; k++) bank[k] = '0;
    #17;
    check("rst_ctl", {busy, done, rd_en, rd_sel, clr_en, clr_sel,
      wr.out_valid}, 32'd0);
    check("rst_bus", {wr.out_data, wr.out_addr}, 32'd0);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_ctl", {busy, done, rd_en, rd_sel, clr_en, clr_sel,
        wr.out_valid}, 32'd0);
      check("idle_bus", {wr.out_data, wr.out_addr}, 32'd0);
    end

    for (int k = 0; k < NUM_REG; k++) bank[k] = PSUM_BW'(k * 3 - 20);
    drain(16, 'h100, 0);

    rand_bank();
    rmode = 2;
    drain(3, 'h020, 0);
    check("bp_stalled", 32'(stall), 32'd5);
    rmode = 0;

    rand_bank();
    drain(0, 'h055, 0);
    drain(20, 'h200, 0);
    rand_bank();
    drain(2, 'h7FF, 0);

    bank[0] = -16'sd5;
    bank[1] = 16'sd7;
    bank[2] = -16'sd32768;
    bank[3] = 16'sd32767;
    drain(4, 'h010, 0);

    rand_bank();
    drain(5, 'h300, 3);

    rmode = 1;
    for (int t = 0; t < 8; t++) begin
      rand_bank();
      drain($urandom_range(0, 20), $urandom_range(0, 2047), 0);
    end
    rmode = 0;

    rand_bank();
    for (int k = 0; k < NUM_REG; k++) snap[k] = bank[k];
    for (int k = 0; k < NUM_REG; k++) begin
      exp_d.push_back(f_ref(bank[k]));
      exp_a.push_back(ADDR_W'('h400 + k));
    end
    n_done = 0;
    acc_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    len = 5'd16;
    base_addr = 'h400;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (acc_cnt == 4 && wr.out_valid) break;
    end
    check("abort_at_w4", 32'(acc_cnt), 32'd4);
    reset = 1'b0;
    #1;
    check("abort_ctl", {busy, done, rd_en, rd_sel, clr_en, clr_sel,
      wr.out_valid}, 32'd0);
    check("abort_bus", {wr.out_data, wr.out_addr}, 32'd0);
    exp_d.delete();
    exp_a.delete();
    exp_c.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int k = 0; k < NUM_REG; k++)
      check("abort_bank", 32'(bank[k]), (k < 4) ? 32'd0 : 32'(snap[k]));

    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
